// File: rtl/step_sequence_scheduler.sv
// +-----------------------------------------------------------------------------+
// | step_sequence_scheduler: round-robin sharing of one mod-N +1/+2 step counter |
// | Optional: STEP_SCHED_POS_CHECK_EN adds a sticky feedback-mismatch flag.      |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module step_sequence_scheduler #(
  parameter int N = 7,
  parameter int W = 4
) (
  input  logic         clock_div,
  input  logic         reset,
  input  logic         req_a,
  input  logic [W-1:0] tgt_a,
  input  logic         req_b,
  input  logic [W-1:0] tgt_b,
  input  logic [W-1:0] pos_fb,
  output logic         step_en,
  output logic         step_dbl,
  output logic [W-1:0] pos,
  output logic         busy,
  output logic         done_a,
  output logic         done_b,
  output logic         err,
  output logic         pos_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [W:0] N_X     = (W+1)'(N);

  logic [1:0]   state_q, state_d;
  logic         owner_q, owner_d;   // 0 = A, 1 = B
  logic         pref_b_q, pref_b_d;
  logic         rej_q, rej_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] pos_q, pos_d;

  logic [W:0]   diff_w, dist_w, step_sum_w, step_next_w;
  logic         pick_b_w;

  // Forward distance in W+1 bits; pos < N keeps the sum below 2N.
  assign diff_w      = {1'b0, tgt_q} + N_X - {1'b0, pos_q};
  assign dist_w      = (diff_w >= N_X) ? (diff_w - N_X) : diff_w;
  assign step_sum_w  = {1'b0, pos_q} + ((rem_q >= W'(2)) ? (W+1)'(2) : (W+1)'(1));
  assign step_next_w = (step_sum_w >= N_X) ? (step_sum_w - N_X) : step_sum_w;
  assign pick_b_w    = req_b & (~req_a | pref_b_q);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    pref_b_d = pref_b_q;
    rej_d    = rej_q;
    tgt_d    = tgt_q;
    rem_d    = rem_q;
    pos_d    = pos_q;
    case (state_q)
      S_IDLE: begin
        if (req_a | req_b) begin
          owner_d = pick_b_w;
          tgt_d   = pick_b_w ? tgt_b : tgt_a;
          rej_d   = 1'b0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if ({1'b0, tgt_q} >= N_X) begin
          rej_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          rem_d   = dist_w[W-1:0];
          state_d = (dist_w == '0) ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        // Double steps first; a lone +1 only when one position remains.
        rem_d = (rem_q >= W'(2)) ? (rem_q - W'(2)) : '0;
        pos_d = step_next_w[W-1:0];
        if (rem_q <= W'(2)) state_d = S_DONE;
      end
      default: begin
        pref_b_d = ~owner_q;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_div or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      pref_b_q <= 1'b0;
      rej_q    <= 1'b0;
      tgt_q    <= '0;
      rem_q    <= '0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      pref_b_q <= pref_b_d;
      rej_q    <= rej_d;
      tgt_q    <= tgt_d;
      rem_q    <= rem_d;
      pos_q    <= pos_d;
    end
  end

  assign step_en  = (state_q == S_STEP);
  assign step_dbl = step_en & (rem_q >= W'(2));
  assign pos      = pos_q;
  assign busy     = (state_q == S_GRANT) | (state_q == S_STEP);
  assign done_a   = (state_q == S_DONE) & ~owner_q;
  assign done_b   = (state_q == S_DONE) & owner_q;
  assign err      = (state_q == S_DONE) & rej_q;

`ifdef STEP_SCHED_POS_CHECK_EN
  logic pos_err_q;

  // Feedback lags the counter while stepping, so only settled states compare.
  always_ff @(posedge clock_div or negedge reset) begin
    if (!reset) begin
      pos_err_q <= 1'b0;
    end else if ((state_q != S_STEP) && (pos_fb != pos_q)) begin
      pos_err_q <= 1'b1;
    end
  end

  assign pos_err = pos_err_q;
`else
  logic unused_pos_fb;

  assign unused_pos_fb = ^pos_fb;
  assign pos_err       = 1'b0;
`endif

endmodule

`default_nettype wire
